time_set_rx: RTL and testbench
==============================

# time_set_rx

UART time-set receiver for the wall clock: accepts an ASCII set-time message over a serial line, validates it, and presents a BCD HH:MM value with a one-cycle load strobe. It sits between the board's USB-UART RX pin and the clock core's time registers. The core copies `hours1`/`hours2`/`mins1`/`mins2` into its own counters when `load` pulses. This is the inbound (setting) path; the display path is the outbound one.

## Interface
- `CLK_FREQ`, default 100000000: clock frequency in Hz.
- `BAUD`, default 9600: serial bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division), minimum 4.
- `CLK100MHZ` input 1: system clock, all logic on rising edge.
- `res` input 1: reset, asynchronous, active-low.
- `rx` input 1: asynchronous serial input, 8N1, idle high, LSB first.
- `load` output 1: one-cycle pulse, a new valid time is on the digit outputs.
- `err` output 1: one-cycle pulse, framing error or message rejected.
- `busy` output 1: high while a message is partially received.
- `hours1` output 4: hours tens, BCD 0-2.
- `hours2` output 4: hours units, BCD 0-9 (0-3 when `hours1`=2).
- `mins1` output 4: minutes tens, BCD 0-5.
- `mins2` output 4: minutes units, BCD 0-9.

## Operation
- Reset (`res`=0, any time, effective immediately):
  - All digit outputs = 0; `load`=0, `err`=0, `busy`=0.
  - Both FSMs return to IDLE.
  - Synchronizer flops are set to 1.
- Input path: `rx` passes through a 2-flop synchronizer. All sampling uses the synchronized signal `rxs`.
- Bit FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `rxs`=0 → START, bit counter cleared.
  - START: sample at count `CLKS_PER_BIT/2`. If `rxs`=1 (false start) → IDLE, nothing reported. If `rxs`=0 → DATA.
  - DATA: sample every `CLKS_PER_BIT` clocks (bit centres), 8 bits into a shift register, LSB first, then → STOP.
  - STOP: sample at the stop-bit centre. If `rxs`=1, issue internal `byte_valid` for one cycle with the byte. If `rxs`=0, pulse `err`, discard the byte, force the parser to P_IDLE. Either way → IDLE; the next start edge is accepted immediately.
- Message format: `T` (0x54), then `H1 H2 M1 M2` as ASCII digits, then CR (0x0D).
- Parser FSM, one transition per `byte_valid`: P_IDLE, P_H1, P_H2, P_M1, P_M2, P_CR.
  - P_IDLE: `T` → P_H1. Any other byte is ignored silently, no `err`.
  - P_H1: accepts `0`-`2` → P_H2.
  - P_H2: accepts `0`-`9` if H1<2, `0`-`3` if H1=2 → P_M1.
  - P_M1: accepts `0`-`5` → P_M2.
  - P_M2: accepts `0`-`9` → P_CR.
  - P_CR: CR → digit outputs loaded from shadow registers, `load` pulses, → P_IDLE.
  - Accepted digits go into shadow registers as (byte − 0x30), 4 bits. Outputs do not change until `load`.
  - Any rejected byte in P_H1..P_CR: `err` pulses, → P_IDLE. Exception: a `T` → `err` pulses and the parser goes to P_H1 (restart).
- `busy` = (parser state ≠ P_IDLE).
- `load` and `err` never assert in the same cycle. Digit outputs hold between loads and never take an out-of-range value.

## Timing
- Start edge is detected 2 cycles after the `rx` fall (synchronizer latency).
- Bit sample points: `CLKS_PER_BIT/2 + k*CLKS_PER_BIT` clocks after start detection, k = 0 (start) through 9 (stop).
- `byte_valid` (or framing `err`) is registered 1 cycle after the stop sample.
- Parser reaction is 1 cycle after `byte_valid`:
  - `load` is high, and the new digits are visible, exactly 2 cycles after the CR stop sample.
  - Parser `err` is 2 cycles after the offending byte's stop sample.
  - Framing `err` is 1 cycle after the stop sample.
- Back-to-back frames (stop bit followed directly by the next start bit) are received without loss.
- A glitch low for fewer than `CLKS_PER_BIT/2` cycles produces no byte and no `err`.
- Reset asserted mid-frame or mid-message discards everything. The first full message after release is received normally.

## Test plan
Bench uses `CLK_FREQ`=1000, `BAUD`=100 (10 clocks/bit) and ideal 8N1 frames.
- Send "T2359\r" → single `load` pulse 2 cycles after the CR stop sample; outputs 2,3,5,9; `err` never high; `busy` high from first `T` byte until `load`.
- Send "T2400\r" → `err` pulses once (at the `4` byte), no `load`, outputs remain 0,0,0,0; `busy` returns 0 after the error.
- Send `T` with stop bit driven 0, then "T0815\r" → framing `err` once; then `load` with 0,8,1,5.
- Send "T12T0745\r" → `err` pulse at the second `T`; then `load` with 0,7,4,5; exactly one `err`, one `load`.
- Drive `rx` low for 3 clocks, then send "xyT1100\r" → the glitch and `x`,`y` cause no `err`; `load` with 1,1,0,0.
- After a loaded value 1,1,0,0: send "T12", assert `res`=0 mid-frame of the next byte, release, send "T0100\r" → outputs 0 and `busy` 0 during reset; then `load` with 0,1,0,0.

Source files
------------

// File: rtl/time_set_rx_if.sv
// time_set_rx_if: serial input and time-set outputs of the UART time-set receiver
interface time_set_rx_if;
   logic       rx;
   logic       load;
   logic       err;
   logic       busy;
   logic [3:0] hours1;
   logic [3:0] hours2;
   logic [3:0] mins1;
   logic [3:0] mins2;
   modport master (output rx, input load, err, busy, hours1, hours2, mins1, mins2);
   modport slave  (input rx, output load, err, busy, hours1, hours2, mins1, mins2);
endinterface

// File: rtl/time_set_rx.sv
// time_set_rx: 8N1 receiver that parses "T HH MM CR" and loads validated BCD time
module time_set_rx #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600
) (
   input logic          CLK100MHZ,
   input logic          res,
   time_set_rx_if.slave bus
);
   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_t;
   typedef enum logic [2:0] {P_IDLE, P_H1, P_H2, P_M1, P_M2, P_CR} par_t;

   bit_t          r_bst;
   par_t          r_pst;
   logic          r_s1, r_s2;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_nbit;
   logic [7:0]    r_shift;
   logic          r_bv, r_ferr, r_perr, r_load;
   logic [3:0]    r_sd_h1, r_sd_h2, r_sd_m1, r_sd_m2;
   logic [3:0]    r_hours1, r_hours2, r_mins1, r_mins2;
   logic          w_rxs, w_num, w_t, w_ok;
   logic [3:0]    w_dig;

   assign w_rxs = r_s2;
   assign w_dig = r_shift[3:0];
   assign w_num = (r_shift[7:4] == 4'h3) && (w_dig <= 4'd9);
   assign w_t   = (r_shift == 8'h54);
   // H2 range depends on the already accepted H1 so that 24:xx and above never pass
   assign w_ok  = (r_pst == P_H1) ? (w_num && w_dig <= 4'd2) :
                  (r_pst == P_H2) ? (w_num && w_dig <= ((r_sd_h1 == 4'd2) ? 4'd3 : 4'd9)) :
                  (r_pst == P_M1) ? (w_num && w_dig <= 4'd5) :
                  (r_pst == P_M2) ? w_num :
                  (r_shift == 8'h0D);

   assign bus.load   = r_load;
   assign bus.err    = r_ferr | r_perr;
   assign bus.busy   = (r_pst != P_IDLE);
   assign bus.hours1 = r_hours1;
   assign bus.hours2 = r_hours2;
   assign bus.mins1  = r_mins1;
   assign bus.mins2  = r_mins2;

   // Two-flop synchronizer, preset to the idle line level
   always_ff @(posedge CLK100MHZ or negedge res)
      if (!res) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= bus.rx;
         r_s2 <= r_s1;
      end

   // Bit FSM: centre-samples start, 8 data bits LSB first and stop; flags byte or framing error
   always_ff @(posedge CLK100MHZ or negedge res)
      if (!res) begin
         r_bst   <= IDLE;
         r_cnt   <= '0;
         r_nbit  <= '0;
         r_shift <= '0;
         r_bv    <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_bv   <= 1'b0;
         r_ferr <= 1'b0;
         case (r_bst)
            IDLE: begin
               r_cnt <= '0;
               if (!w_rxs) r_bst <= START;
            end
            START:
               if (r_cnt == CW'(HALF - 1)) begin
                  r_cnt  <= '0;
                  r_nbit <= '0;
                  r_bst  <= w_rxs ? IDLE : DATA;
               end else r_cnt <= r_cnt + 1'b1;
            DATA:
               if (r_cnt == CW'(CPB - 1)) begin
                  r_cnt   <= '0;
                  r_shift <= {w_rxs, r_shift[7:1]};
                  r_nbit  <= r_nbit + 1'b1;
                  if (r_nbit == 3'd7) r_bst <= STOP;
               end else r_cnt <= r_cnt + 1'b1;
            STOP:
               if (r_cnt == CW'(CPB - 1)) begin
                  r_cnt  <= '0;
                  r_bst  <= IDLE;
                  r_bv   <= w_rxs;
                  r_ferr <= !w_rxs;
               end else r_cnt <= r_cnt + 1'b1;
            default: r_bst <= IDLE;
         endcase
      end

   // Parser FSM: one step per received byte; digits stay in shadows until the closing CR
   always_ff @(posedge CLK100MHZ or negedge res)
      if (!res) begin
         r_pst    <= P_IDLE;
         r_load   <= 1'b0;
         r_perr   <= 1'b0;
         r_sd_h1  <= '0;
         r_sd_h2  <= '0;
         r_sd_m1  <= '0;
         r_sd_m2  <= '0;
         r_hours1 <= '0;
         r_hours2 <= '0;
         r_mins1  <= '0;
         r_mins2  <= '0;
      end else begin
         r_load <= 1'b0;
         r_perr <= 1'b0;
         if (r_ferr) r_pst <= P_IDLE;
         else if (r_bv) begin
            if (r_pst == P_IDLE) begin
               if (w_t) r_pst <= P_H1;
            end else if (!w_ok) begin
               r_perr <= 1'b1;
               r_pst  <= w_t ? P_H1 : P_IDLE;
            end else
               case (r_pst)
                  P_H1: begin
                     r_sd_h1 <= w_dig;
                     r_pst   <= P_H2;
                  end
                  P_H2: begin
                     r_sd_h2 <= w_dig;
                     r_pst   <= P_M1;
                  end
                  P_M1: begin
                     r_sd_m1 <= w_dig;
                     r_pst   <= P_M2;
                  end
                  P_M2: begin
                     r_sd_m2 <= w_dig;
                     r_pst   <= P_CR;
                  end
                  default: begin
                     r_hours1 <= r_sd_h1;
                     r_hours2 <= r_sd_h2;
                     r_mins1  <= r_sd_m1;
                     r_mins2  <= r_sd_m2;
                     r_load   <= 1'b1;
                     r_pst    <= P_IDLE;
                  end
               endcase
         end
      end
endmodule

// File: tb/tb_time_set_rx.sv
// tb_time_set_rx: directed serial messages against hand-computed time, pulse and timing values
module tb_time_set_rx;
   localparam int CPB = 10;

   logic clk = 1'b0;
   logic res = 1'b0;
   int   cyc = 0;
   int   n_chk = 0, n_pass = 0, n_fail = 0;
   int   n_load = 0, n_err = 0, t_load = -1, t_err = -1, t_start = 0;
   int   l0, e0, t_mark;

   time_set_rx_if bus();

   time_set_rx #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .CLK100MHZ(clk),
      .res(res),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Cycle counter used to time-stamp output pulses
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.load) begin
         n_load = n_load + 1;
         t_load = cyc;
      end
      if (bus.err) begin
         n_err = n_err + 1;
         t_err = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic bit_time();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stp);
      t_start = cyc;
      bus.rx = 1'b0;
      bit_time();
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         bit_time();
      end
      bus.rx = stp;
      bit_time();
      bus.rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_time(input string tag, input logic [3:0] h1, input logic [3:0] h2,
                           input logic [3:0] m1, input logic [3:0] m2);
      chk({tag, "_h1"}, 32'(bus.hours1), 32'(h1));
      chk({tag, "_h2"}, 32'(bus.hours2), 32'(h2));
      chk({tag, "_m1"}, 32'(bus.mins1), 32'(m1));
      chk({tag, "_m2"}, 32'(bus.mins2), 32'(m2));
   endtask

   initial begin
      bus.rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_time("reset", 0, 0, 0, 0);
      chk("reset_load", 32'(bus.load), 0);
      chk("reset_err", 32'(bus.err), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      res = 1'b1;
      idle(20);

      // Out-of-range hour: error at '4', nothing loaded
      l0 = n_load; e0 = n_err;
      send_str("T2");
      chk("t24_busy", 32'(bus.busy), 1);
      send("4", 1'b1);
      t_mark = t_start;
      chk("t24_err_time", 32'(t_err), 32'(t_mark + 99));
      chk("t24_busy_after", 32'(bus.busy), 0);
      send_str("00");
      send(8'h0D, 1'b1);
      idle(5);
      chk("t24_err_cnt", 32'(n_err - e0), 1);
      chk("t24_load_cnt", 32'(n_load - l0), 0);
      chk_time("t24", 0, 0, 0, 0);

      // Valid 23:59
      l0 = n_load; e0 = n_err;
      send("T", 1'b1);
      chk("t2359_busy_t", 32'(bus.busy), 1);
      send_str("2359");
      chk("t2359_busy_m2", 32'(bus.busy), 1);
      chk_time("t2359_hold", 0, 0, 0, 0);
      send(8'h0D, 1'b1);
      t_mark = t_start;
      chk("t2359_load_time", 32'(t_load), 32'(t_mark + 99));
      chk("t2359_busy_after", 32'(bus.busy), 0);
      idle(5);
      chk("t2359_load_cnt", 32'(n_load - l0), 1);
      chk("t2359_err_cnt", 32'(n_err - e0), 0);
      chk_time("t2359", 2, 3, 5, 9);

      // Framing error, then valid 08:15
      l0 = n_load; e0 = n_err;
      send("T", 1'b0);
      t_mark = t_start;
      idle(20);
      chk("ferr_time", 32'(t_err), 32'(t_mark + 98));
      chk("ferr_busy", 32'(bus.busy), 0);
      send_str("T0815");
      send(8'h0D, 1'b1);
      idle(5);
      chk("t0815_err_cnt", 32'(n_err - e0), 1);
      chk("t0815_load_cnt", 32'(n_load - l0), 1);
      chk_time("t0815", 0, 8, 1, 5);

      // Restart with a second 'T' mid-message
      l0 = n_load; e0 = n_err;
      send_str("T12");
      send("T", 1'b1);
      t_mark = t_start;
      chk("restart_err_time", 32'(t_err), 32'(t_mark + 99));
      chk("restart_busy", 32'(bus.busy), 1);
      send_str("0745");
      send(8'h0D, 1'b1);
      idle(5);
      chk("t0745_err_cnt", 32'(n_err - e0), 1);
      chk("t0745_load_cnt", 32'(n_load - l0), 1);
      chk_time("t0745", 0, 7, 4, 5);

      // Short glitch and junk bytes before the message are silent
      l0 = n_load; e0 = n_err;
      bus.rx = 1'b0;
      idle(3);
      bus.rx = 1'b1;
      idle(20);
      chk("glitch_busy", 32'(bus.busy), 0);
      send_str("xy");
      chk("junk_busy", 32'(bus.busy), 0);
      send_str("T1100");
      send(8'h0D, 1'b1);
      idle(5);
      chk("t1100_err_cnt", 32'(n_err - e0), 0);
      chk("t1100_load_cnt", 32'(n_load - l0), 1);
      chk_time("t1100", 1, 1, 0, 0);

      // Reset mid-frame discards everything, then a normal message
      send_str("T12");
      bus.rx = 1'b0;
      idle(25);
      res = 1'b0;
      bus.rx = 1'b1;
      #2;
      chk_time("rst_mid", 0, 0, 0, 0);
      chk("rst_mid_busy", 32'(bus.busy), 0);
      chk("rst_mid_load", 32'(bus.load), 0);
      chk("rst_mid_err", 32'(bus.err), 0);
      idle(3);
      res = 1'b1;
      idle(20);
      l0 = n_load; e0 = n_err;
      send_str("T0100");
      send(8'h0D, 1'b1);
      idle(5);
      chk("t0100_err_cnt", 32'(n_err - e0), 0);
      chk("t0100_load_cnt", 32'(n_load - l0), 1);
      chk_time("t0100", 0, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
